cpu_run_ctrl: RTL and testbench

- Run-control sequencer for the 8-bit RISC core on the Spartan-6 board.
- Debounces the front-panel pushbuttons and turns them into run/pause, single-step and soft-reset commands.
- Gates CPU state advance through a divided one-clock enable, `cpu_en`, which replaces the core's free-running divider.
- Tracks HALT and counts retired instructions for LED or debug display.

---
 rtl/cpu_run_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the 8-bit RISC core: debounced front-panel buttons drive
// run/pause, single-step and soft reset; CPU advance is gated through a divided enable.
module cpu_run_ctrl #(
    parameter int unsigned DIV_W = 11,
    parameter int unsigned DEB_W = 16
) (
    input  logic       CLK_12MHz,
    input  logic       RST_n,
    input  logic       btn_run_n,
    input  logic       btn_step_n,
    input  logic       btn_reset_n,
    input  logic       cpu_halt,
    input  logic       cpu_instr_done,
    output logic       cpu_en,
    output logic       cpu_soft_rst,
    output logic [1:0] state_o,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StHalted = 2'd3
    } state_e;

    localparam int NumBtn = 3;
    localparam int BtnRun = 0;
    localparam int BtnStep = 1;
    localparam int BtnReset = 2;

    localparam logic [DEB_W-1:0] DebMax = '1;
    localparam logic [DEB_W-1:0] DebOne = DEB_W'(1);
    localparam logic [DIV_W-1:0] DivMax = '1;
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    logic [NumBtn-1:0] deb_q;
    logic [NumBtn-1:0] deb_d;
    logic [NumBtn-1:0] press;
    logic [DEB_W-1:0]  deb_cnt_q [NumBtn];
    logic [DEB_W-1:0]  deb_cnt_d [NumBtn];

    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;
    logic             en_q;
    logic             en_d;
    logic             srst_q;
    logic             srst_d;

    logic wrap;
    logic active;
    logic rst_evt;
    logic run_evt;
    logic step_evt;

    assign btn_raw = {btn_reset_n, btn_step_n, btn_run_n};

    // Counter runs only while the synced level disagrees with the debounced one; any
    // bounce back to agreement clears it. Press fires on the clock the level falls.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = deb_cnt_q[i];
            press[i]     = 1'b0;
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DebMax) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
                press[i]     = deb_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DebOne;
            end
        end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            for (int i = 0; i < NumBtn; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < NumBtn; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign rst_evt  = press[BtnReset];
    assign run_evt  = press[BtnRun];
    assign step_evt = press[BtnStep];
    assign wrap     = (div_q == DivMax);
    assign active   = (state_q == StRun) || (state_q == StStep);

    always_comb begin
        state_d = state_q;
        if (rst_evt) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_evt) begin
                        state_d = StRun;
                    end else if (step_evt) begin
                        state_d = StStep;
                    end
                end
                StRun: begin
                    if (cpu_halt) begin
                        state_d = StHalted;
                    end else if (run_evt) begin
                        state_d = StIdle;
                    end
                end
                StStep: begin
                    if (cpu_halt) begin
                        state_d = StHalted;
                    end else if (cpu_instr_done) begin
                        state_d = StIdle;
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        div_d   = rst_evt ? '0 : div_q + DivOne;
        // Enable only when staying in RUN/STEP, so leaving never emits a trailing pulse.
        en_d    = wrap && active && (state_d == state_q);
        srst_d  = rst_evt;
        count_d = count_q;
        if (rst_evt) begin
            count_d = '0;
        end else if (cpu_instr_done && active) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            en_q    <= en_d;
            srst_q  <= srst_d;
        end
    end

    assign cpu_en       = en_q;
    assign cpu_soft_rst = srst_q;
    assign state_o      = state_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a 4-clock divider and 2-bit debounce counters.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_run_n;
    logic       btn_step_n;
    logic       btn_reset_n;
    logic       cpu_halt;
    logic       cpu_instr_done;
    logic       cpu_en;
    logic       cpu_soft_rst;
    logic [1:0] state_o;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_pulses = 0;
    int en_consec = 0;
    int en_badgap = 0;
    int last_en = -1;
    logic prev_en = 1'b0;
    int srst_pulses = 0;
    int lat;
    int guard;

    cpu_run_ctrl #(
        .DIV_W(2),
        .DEB_W(2)
    ) dut (
        .CLK_12MHz     (clk),
        .RST_n         (rst_n),
        .btn_run_n     (btn_run_n),
        .btn_step_n    (btn_step_n),
        .btn_reset_n   (btn_reset_n),
        .cpu_halt      (cpu_halt),
        .cpu_instr_done(cpu_instr_done),
        .cpu_en        (cpu_en),
        .cpu_soft_rst  (cpu_soft_rst),
        .state_o       (state_o),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_en_stats();
        en_pulses = 0;
        en_consec = 0;
        en_badgap = 0;
        last_en   = -1;
        prev_en   = cpu_en;
    endtask

    // One clock; samples 1 time unit after the rising edge and tracks enable spacing.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_en === 1'b1) begin
            if (prev_en === 1'b1) en_consec++;
            if (last_en >= 0 && (cyc - last_en) != 4) en_badgap++;
            last_en = cyc;
            en_pulses++;
        end
        prev_en = cpu_en;
        if (cpu_soft_rst === 1'b1) srst_pulses++;
    endtask

    // mask bit 0 run, 1 step, 2 reset. lat = ticks from drive to state change, else -1.
    task automatic press_btn(input logic [2:0] mask, output int lat_o);
        logic [1:0] st0;
        repeat (8) tick();
        st0         = state_o;
        lat_o       = -1;
        srst_pulses = 0;
        btn_run_n   = ~mask[0];
        btn_step_n  = ~mask[1];
        btn_reset_n = ~mask[2];
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (lat_o < 0 && state_o !== st0) begin
                lat_o     = i;
                en_pulses = 0;
            end
        end
        btn_run_n   = 1'b1;
        btn_step_n  = 1'b1;
        btn_reset_n = 1'b1;
    endtask

    task automatic pulse_done();
        cpu_instr_done = 1'b1;
        tick();
        cpu_instr_done = 1'b0;
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        btn_run_n      = 1'b1;
        btn_step_n     = 1'b1;
        btn_reset_n    = 1'b1;
        cpu_halt       = 1'b0;
        cpu_instr_done = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_en", 32'(cpu_en), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_srst", 32'(cpu_soft_rst), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_en", 32'(cpu_en), 32'd0);

        // Single-clock glitch must not survive the debounce.
        btn_run_n = 1'b0;
        tick();
        btn_run_n = 1'b1;
        repeat (10) tick();
        check("glitch_state", 32'(state_o), 32'd0);

        // 2 sync + 3 count clocks, state lands on the 6th edge.
        press_btn(3'b001, lat);
        check("run_lat", 32'(lat), 32'd6);
        check("run_state", 32'(state_o), 32'd1);
        clear_en_stats();
        repeat (40) tick();
        check("run_en_count", 32'(en_pulses), 32'd10);
        check("run_en_consec", 32'(en_consec), 32'd0);
        check("run_en_gap", 32'(en_badgap), 32'd0);
        check("run_one_event", 32'(state_o), 32'd1);
        check("run_count0", 32'(instr_count), 32'd0);

        press_btn(3'b001, lat);
        check("pause_lat", 32'(lat), 32'd6);
        repeat (20) tick();
        check("pause_state", 32'(state_o), 32'd0);
        check("pause_no_en", 32'(en_pulses), 32'd0);

        press_btn(3'b010, lat);
        check("step_lat", 32'(lat), 32'd6);
        check("step_state", 32'(state_o), 32'd2);
        guard = 0;
        while (en_pulses < 3 && guard < 100) begin
            tick();
            guard++;
        end
        check("step_en3", 32'(en_pulses), 32'd3);
        check("step_still_step", 32'(state_o), 32'd2);
        cpu_instr_done = 1'b1;
        tick();
        cpu_instr_done = 1'b0;
        check("step_done_state", 32'(state_o), 32'd0);
        check("step_done_count", 32'(instr_count), 32'd1);
        en_pulses = 0;
        repeat (20) tick();
        check("step_no_en", 32'(en_pulses), 32'd0);
        pulse_done();
        check("idle_done_ignored", 32'(instr_count), 32'd1);
        cpu_halt = 1'b1;
        repeat (3) tick();
        check("idle_halt_ignored", 32'(state_o), 32'd0);
        cpu_halt = 1'b0;

        press_btn(3'b001, lat);
        check("run2_state", 32'(state_o), 32'd1);
        for (int i = 0; i < 254; i++) pulse_done();
        check("count_255", 32'(instr_count), 32'd255);
        pulse_done();
        check("count_wrap", 32'(instr_count), 32'd0);

        cpu_halt = 1'b1;
        tick();
        check("halt_state", 32'(state_o), 32'd3);
        en_pulses = 0;
        repeat (20) tick();
        check("halt_no_en", 32'(en_pulses), 32'd0);
        cpu_halt = 1'b0;
        pulse_done();
        check("halt_done_ignored", 32'(instr_count), 32'd0);
        press_btn(3'b001, lat);
        check("halt_run_lat", 32'(lat), 32'hFFFF_FFFF);
        check("halt_run_state", 32'(state_o), 32'd3);
        press_btn(3'b010, lat);
        check("halt_step_state", 32'(state_o), 32'd3);
        press_btn(3'b100, lat);
        repeat (3) tick();
        check("srst_lat", 32'(lat), 32'd6);
        check("srst_pulses", 32'(srst_pulses), 32'd1);
        check("srst_state", 32'(state_o), 32'd0);
        check("srst_count", 32'(instr_count), 32'd0);

        // Reset and run presses debounced on the same clock: reset wins.
        press_btn(3'b001, lat);
        check("run3_state", 32'(state_o), 32'd1);
        repeat (3) pulse_done();
        check("run3_count", 32'(instr_count), 32'd3);
        press_btn(3'b101, lat);
        repeat (3) tick();
        check("both_srst", 32'(srst_pulses), 32'd1);
        check("both_state", 32'(state_o), 32'd0);
        check("both_count", 32'(instr_count), 32'd0);

        // Asynchronous RST_n between edges while cpu_en is high.
        press_btn(3'b001, lat);
        pulse_done();
        check("run4_count", 32'(instr_count), 32'd1);
        guard = 0;
        while (cpu_en !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("async_en_seen", 32'(cpu_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_en", 32'(cpu_en), 32'd0);
        check("async_state", 32'(state_o), 32'd0);
        check("async_count", 32'(instr_count), 32'd0);
        check("async_srst", 32'(cpu_soft_rst), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("after_async_state", 32'(state_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
